laser_cover: RTL and testbench
==============================

# laser_cover

Parametrised multi-circle laser coverage engine, successor to the two-circle 16x16 laser placer. It loads `NPTS` target points, then places `NCIRC` circles of radius `R` on a 2^CW x 2^CW grid by iterative coordinate ascent until the centres stop moving. Each circle's score counts only points not already covered by the other circles. It sits behind the point-stream source and reports centres plus a `DONE` pulse to the scoring/readout logic.

## Interface
- `NPTS`, 40: points per job (2..63)
- `CW`, 4: coordinate width; grid is 0..2^CW-1 on each axis
- `R`, 4: circle radius; a point is inside when dx²+dy² <= R*R
- `NCIRC`, 2: number of circles (1..4)
- `MAX_ROUNDS`, 8: upper bound on ascent rounds
- `CLK`  in  1  clock; one clock domain
- `RST_N`  in  1  reset, synchronous, active-low
- `IN_VALID`  in  1  `X`/`Y` hold a point this cycle
- `X`, `Y`  in  CW  point coordinates
- `BUSY`  out  1  high from first accepted point until `DONE`
- `C_X`, `C_Y`  out  NCIRC*CW  centre of circle k at bits [k*CW +: CW]
- `COVER_CNT`  out  CNTW=$clog2(NPTS+1)  points covered by the union of circles
- `DONE`  out  1  one-cycle pulse, results valid

## Operation
- States:
  - IDLE: first `IN_VALID` -> LOAD.
  - LOAD: stores one point per `IN_VALID` cycle; after NPTS points -> SCAN with k=0, round=1.
  - SCAN: candidates in raster order, y outer then x inner, from (0,0); each candidate takes NPTS cycles, one point per cycle.
  - MARK: NPTS cycles rebuild cov[k].
  - NEXT: k+1, or round end.
  - COUNT and FIN: COUNT when the macro is on; FIN pulses `DONE`.
- Point p scores for circle k when it is inside the candidate circle and `others[p]` = OR of cov[j] over j!=k is 0.
- Best update:
  - The first candidate of a scan always loads best.
  - Afterwards a candidate replaces best only on a strictly greater count, so ties go to the first candidate in raster order.
  - The compare is folded into the last point cycle of each candidate.
- After the scan: if best centre != C[k], set `changed`; write C[k]; MARK cov[k] against the new centre.
- Round end:
  - If `changed`=0 or round==MAX_ROUNDS, go to COUNT/FIN.
  - Otherwise clear `changed`, round+1, k=0, SCAN.
- Arithmetic:
  - dx and dy are signed CW+1 bits.
  - Squares and the sum are unsigned 2CW+3 bits, compared against the constant R*R.
  - Candidates never wrap: edge centres are evaluated as-is.
- Start of job: all C[k] and cov masks are 0. Centres stay at 0 until their circle is written back.
- `IN_VALID` is ignored outside IDLE/LOAD.
- Results hold through FIN until the next job's first accepted point.

## Timing
- Reset (`RST_N`=0 at a `CLK` edge):
  - State -> IDLE.
  - `C_X`=`C_Y`=0, `COVER_CNT`=0, `DONE`=0, `BUSY`=0.
  - All cov masks cleared; point memory not cleared.
- Reset mid-job aborts at the next edge with no `DONE`.
- Load latency: NPTS accepted cycles; bubbles allowed.
- Per circle: 2^(2CW)*NPTS SCAN cycles + NPTS MARK cycles + 1 NEXT cycle.
- Per round: NCIRC times the per-circle figure.
- COUNT: NPTS cycles.
- `DONE`: asserted the cycle after the last COUNT/NEXT cycle; `BUSY` falls in the same cycle.
- Simultaneous `IN_VALID` and FIN→IDLE: the sample is not accepted that cycle.

## Configuration
- `LASER_COVER_COUNT_EN` defined:
  - COUNT state runs.
  - `COVER_CNT` = popcount of OR of all cov masks.
  - Adds NPTS cycles before `DONE`.
- Not defined:
  - No COUNT state.
  - `COVER_CNT` tied to 0; port still present.
  - FIN follows round end directly.

## Structure
- Package `laser_pkg`:
  - State enum.
  - `CNTW` helper function.
  - Radius-squared constant function.
- Sub-module `laser_in_circle`: combinational point/centre/R test.
  - Single instance, shared by SCAN, MARK and COUNT; COUNT uses the cov OR only.
- Top holds the FSM, point RAM (regs), cov masks, counters, best register.

## Test plan
Defaults unless noted.
- All 40 points at (5,5):
  - C0=(5,1), C1=(0,0).
  - 2 rounds, `DONE` pulses once, `COVER_CNT`=40 with macro.
- 20 points at (2,2) and 20 at (12,12):
  - C0=(0,0), C1=(12,8).
  - Round 2 unchanged, so stop; `COVER_CNT`=40.
- Same stimulus as the previous case with random `IN_VALID` bubbles -> identical centres.
- All 40 at (15,15): C0=(15,11). Confirms no wrap and signed edge dx.
- `RST_N` low mid-SCAN:
  - Next cycle all outputs 0 and `BUSY`=0, no `DONE`.
  - A fresh load afterwards gives correct results.
- Macro undefined on the two-cluster case: same centres, `COVER_CNT`=0, `DONE` NPTS cycles earlier.

Source files
------------

// File: rtl/laser_pkg.sv
// Shared types and sizing helpers for the laser coverage engine.
package laser_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SCAN,
        S_MARK,
        S_NEXT,
        S_COUNT,
        S_FIN
    } state_t;

    // Width of a counter that must hold the value n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Width of an index addressing n entries.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned r_sq(input int unsigned r);
        return r * r;
    endfunction

endpackage

// File: rtl/laser_in_circle.sv
// Combinational test: is point (px,py) within radius R of centre (cx,cy).
module laser_in_circle
    import laser_pkg::*;
#(
    parameter int unsigned CW = 4,
    parameter int unsigned R  = 4
) (
    input  logic [CW-1:0] px,
    input  logic [CW-1:0] py,
    input  logic [CW-1:0] cx,
    input  logic [CW-1:0] cy,
    output logic          inside_c
);

    localparam int unsigned DW = CW + 1;
    localparam int unsigned SW = 2 * CW + 3;
    localparam logic [SW-1:0] RR = SW'(r_sq(R));

    logic signed [DW-1:0] dx;
    logic signed [DW-1:0] dy;
    logic        [DW-1:0] ax;
    logic        [DW-1:0] ay;
    logic        [SW-1:0] sum;

    // Squares are taken on magnitudes so the products stay unsigned.
    always_comb begin
        dx       = $signed({1'b0, px}) - $signed({1'b0, cx});
        dy       = $signed({1'b0, py}) - $signed({1'b0, cy});
        ax       = dx[DW-1] ? $unsigned(-dx) : $unsigned(dx);
        ay       = dy[DW-1] ? $unsigned(-dy) : $unsigned(dy);
        sum      = SW'(ax) * SW'(ax) + SW'(ay) * SW'(ay);
        inside_c = (sum <= RR);
    end

endmodule

// File: rtl/laser_cover.sv
// Multi-circle laser coverage engine: loads NPTS points, places NCIRC circles by coordinate ascent.
// Optional LASER_COVER_COUNT_EN adds a COUNT pass that reports the union coverage in cover_cnt.
module laser_cover
    import laser_pkg::*;
#(
    parameter int unsigned NPTS       = 40,
    parameter int unsigned CW         = 4,
    parameter int unsigned R          = 4,
    parameter int unsigned NCIRC      = 2,
    parameter int unsigned MAX_ROUNDS = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [CW-1:0]              x,
    input  logic [CW-1:0]              y,
    output logic                       busy,
    output logic [NCIRC*CW-1:0]        c_x,
    output logic [NCIRC*CW-1:0]        c_y,
    output logic [cnt_width(NPTS)-1:0] cover_cnt,
    output logic                       done
);

    localparam int unsigned CNTW = cnt_width(NPTS);
    localparam int unsigned PW   = idx_width(NPTS);
    localparam int unsigned KW   = idx_width(NCIRC);
    localparam int unsigned RW   = cnt_width(MAX_ROUNDS);
    localparam int unsigned GW   = 2 * CW;

    localparam logic [PW-1:0] LAST_P    = PW'(NPTS - 1);
    localparam logic [KW-1:0] LAST_K    = KW'(NCIRC - 1);
    localparam logic [RW-1:0] LAST_R    = RW'(MAX_ROUNDS);
    localparam logic [GW-1:0] LAST_CAND = '1;
`ifdef LASER_COVER_COUNT_EN
    localparam state_t AFTER_ROUNDS = S_COUNT;
`else
    localparam state_t AFTER_ROUNDS = S_FIN;
`endif

    state_t state;
    state_t state_nx;
    logic   busy_nx;
    logic   done_nx;

    logic [CW-1:0]   mem_x [NPTS];
    logic [CW-1:0]   mem_y [NPTS];
    logic [NPTS-1:0] cov   [NCIRC];

    logic [PW-1:0]   pidx;
    logic [GW-1:0]   cand;
    logic [KW-1:0]   k;
    logic [RW-1:0]   round;
    logic [CNTW-1:0] acc;
    logic [CNTW-1:0] best_cnt;
    logic [GW-1:0]   best_pos;
    logic            changed;

    logic            last_p;
    logic            last_cand;
    logic [CW-1:0]   cur_cx;
    logic [CW-1:0]   cur_cy;
    logic [CW-1:0]   test_cx;
    logic [CW-1:0]   test_cy;
    logic            in_circ_c;
    logic            others;
    logic            hit;
    logic            add_bit;
    logic [CNTW-1:0] tot;
    logic            take;
    logic [GW-1:0]   fin_pos;
`ifdef LASER_COVER_COUNT_EN
    logic            union_bit;
`endif

    // Single distance tester; MARK checks stored centres, SCAN checks candidates.
    laser_in_circle #(
        .CW (CW),
        .R  (R)
    ) u_in_circle (
        .px       (mem_x[pidx]),
        .py       (mem_y[pidx]),
        .cx       (test_cx),
        .cy       (test_cy),
        .inside_c (in_circ_c)
    );

    always_comb begin
        last_p    = (pidx == LAST_P);
        last_cand = (cand == LAST_CAND);
        cur_cx    = '0;
        cur_cy    = '0;
        others    = 1'b0;
        for (int j = 0; j < int'(NCIRC); j++) begin
            if (k == KW'(j)) begin
                cur_cx = c_x[j*CW +: CW];
                cur_cy = c_y[j*CW +: CW];
            end else begin
                others = others | cov[j][pidx];
            end
        end
        test_cx = (state == S_MARK) ? cur_cx : cand[CW-1:0];
        test_cy = (state == S_MARK) ? cur_cy : cand[GW-1:CW];
        hit     = in_circ_c && !others;
`ifdef LASER_COVER_COUNT_EN
        union_bit = 1'b0;
        for (int j = 0; j < int'(NCIRC); j++) begin
            union_bit = union_bit | cov[j][pidx];
        end
        add_bit = (state == S_COUNT) ? union_bit : hit;
`else
        add_bit = hit;
`endif
        tot     = acc + CNTW'(add_bit);
        // First candidate always loads; later ones need a strictly larger count.
        take    = (cand == '0) || (tot > best_cnt);
        fin_pos = take ? cand : best_pos;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (in_valid) state_nx = S_LOAD;
            S_LOAD:  if (in_valid && last_p) state_nx = S_SCAN;
            S_SCAN:  if (last_p && last_cand) state_nx = S_MARK;
            S_MARK:  if (last_p) state_nx = S_NEXT;
            S_NEXT: begin
                if (k != LAST_K || (changed && round != LAST_R)) begin
                    state_nx = S_SCAN;
                end else begin
                    state_nx = AFTER_ROUNDS;
                end
            end
            S_COUNT: if (last_p) state_nx = S_FIN;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy_nx = 1'b1;
        done_nx = 1'b0;
        if (state_nx == S_IDLE || state_nx == S_FIN) begin
            busy_nx = 1'b0;
        end
        if (state_nx == S_FIN) begin
            done_nx = 1'b1;
        end
    end

    // Point memory is never reset; it is always fully rewritten by LOAD.
    always_ff @(posedge clk) begin
        if (in_valid && (state == S_IDLE || state == S_LOAD)) begin
            mem_x[(state == S_IDLE) ? '0 : pidx] <= x;
            mem_y[(state == S_IDLE) ? '0 : pidx] <= y;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pidx     <= '0;
            cand     <= '0;
            k        <= '0;
            round    <= '0;
            acc      <= '0;
            best_cnt <= '0;
            best_pos <= '0;
            changed  <= 1'b0;
            c_x      <= '0;
            c_y      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            for (int j = 0; j < int'(NCIRC); j++) begin
                cov[j] <= '0;
            end
        end else begin
            busy <= busy_nx;
            done <= done_nx;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        pidx <= PW'(1);
                        c_x  <= '0;
                        c_y  <= '0;
                        for (int j = 0; j < int'(NCIRC); j++) begin
                            cov[j] <= '0;
                        end
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        if (last_p) begin
                            pidx    <= '0;
                            cand    <= '0;
                            k       <= '0;
                            round   <= RW'(1);
                            acc     <= '0;
                            changed <= 1'b0;
                        end else begin
                            pidx <= pidx + PW'(1);
                        end
                    end
                end
                S_SCAN: begin
                    if (last_p) begin
                        pidx <= '0;
                        acc  <= '0;
                        cand <= cand + GW'(1);
                        if (take) begin
                            best_cnt <= tot;
                            best_pos <= cand;
                        end
                        // End of scan: write the winner back as this circle's centre.
                        if (last_cand) begin
                            for (int j = 0; j < int'(NCIRC); j++) begin
                                if (k == KW'(j)) begin
                                    c_x[j*CW +: CW] <= fin_pos[CW-1:0];
                                    c_y[j*CW +: CW] <= fin_pos[GW-1:CW];
                                end
                            end
                            if (fin_pos != {cur_cy, cur_cx}) begin
                                changed <= 1'b1;
                            end
                        end
                    end else begin
                        pidx <= pidx + PW'(1);
                        acc  <= tot;
                    end
                end
                S_MARK: begin
                    for (int j = 0; j < int'(NCIRC); j++) begin
                        if (k == KW'(j)) begin
                            cov[j][pidx] <= in_circ_c;
                        end
                    end
                    pidx <= last_p ? '0 : pidx + PW'(1);
                end
                S_NEXT: begin
                    if (k != LAST_K) begin
                        k <= k + KW'(1);
                    end else begin
                        k <= '0;
                        if (state_nx == S_SCAN) begin
                            round   <= round + RW'(1);
                            changed <= 1'b0;
                        end
                    end
                end
                S_COUNT: begin
                    acc  <= last_p ? '0 : tot;
                    pidx <= last_p ? '0 : pidx + PW'(1);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef LASER_COVER_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cover_cnt <= '0;
        end else if (state == S_IDLE && in_valid) begin
            cover_cnt <= '0;
        end else if (state == S_COUNT && last_p) begin
            cover_cnt <= tot;
        end
    end
`else
    assign cover_cnt = '0;
`endif

endmodule

// File: tb/tb_laser_cover.sv
// Self-checking bench for laser_cover: directed jobs plus randomized jobs against a behavioural model.
module tb_laser_cover;

    localparam int unsigned TN       = 5;
    localparam int unsigned TCW      = 4;
    localparam int unsigned TR       = 4;
    localparam int unsigned TNC      = 2;
    localparam int unsigned TMR      = 4;
    localparam int unsigned CNTW     = $clog2(TN + 1);
    localparam int unsigned CXW      = TNC * TCW;
    localparam int unsigned GRID     = 1 << TCW;
    localparam int unsigned PER_CIRC = GRID * GRID * TN + TN + 1;
`ifdef LASER_COVER_COUNT_EN
    localparam int unsigned COUNT_CYC = TN;
    localparam bit          COUNT_ON  = 1'b1;
`else
    localparam int unsigned COUNT_CYC = 0;
    localparam bit          COUNT_ON  = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic [TCW-1:0]  x;
    logic [TCW-1:0]  y;
    logic            busy;
    logic [CXW-1:0]  c_x;
    logic [CXW-1:0]  c_y;
    logic [CNTW-1:0] cover_cnt;
    logic            done;

    int px [TN];
    int py [TN];
    int mcx [TNC];
    int mcy [TNC];
    int m_rounds;
    int m_union;
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    laser_cover #(
        .NPTS       (TN),
        .CW         (TCW),
        .R          (TR),
        .NCIRC      (TNC),
        .MAX_ROUNDS (TMR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .busy      (busy),
        .c_x       (c_x),
        .c_y       (c_y),
        .cover_cnt (cover_cnt),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [CXW-1:0] pack2(input int c0, input int c1);
        logic [CXW-1:0] v;
        v = '0;
        v[0 +: TCW]   = TCW'(c0);
        v[TCW +: TCW] = TCW'(c1);
        return v;
    endfunction

    function automatic int lat(input int rounds);
        return rounds * int'(TNC * PER_CIRC) + int'(COUNT_CYC);
    endfunction

    function automatic bit in_circ(input int ax, input int ay, input int bx, input int by);
        return ((ax - bx) * (ax - bx) + (ay - by) * (ay - by)) <= int'(TR * TR);
    endfunction

    // Coordinate ascent straight from the placement rules, on plain integers.
    task automatic run_model();
        bit cov [TNC][TN];
        bit changed;
        bit oth;
        int best;
        int cnt;
        int bx;
        int by;
        for (int k = 0; k < int'(TNC); k++) begin
            mcx[k] = 0;
            mcy[k] = 0;
            for (int p = 0; p < int'(TN); p++) cov[k][p] = 1'b0;
        end
        m_rounds = 0;
        for (int r = 1; r <= int'(TMR); r++) begin
            m_rounds = r;
            changed  = 1'b0;
            for (int k = 0; k < int'(TNC); k++) begin
                best = -1;
                bx   = 0;
                by   = 0;
                for (int cy = 0; cy < int'(GRID); cy++) begin
                    for (int cx = 0; cx < int'(GRID); cx++) begin
                        cnt = 0;
                        for (int p = 0; p < int'(TN); p++) begin
                            oth = 1'b0;
                            for (int j = 0; j < int'(TNC); j++) if (j != k) oth |= cov[j][p];
                            if (!oth && in_circ(px[p], py[p], cx, cy)) cnt++;
                        end
                        if (cnt > best) begin
                            best = cnt;
                            bx   = cx;
                            by   = cy;
                        end
                    end
                end
                if (bx != mcx[k] || by != mcy[k]) changed = 1'b1;
                mcx[k] = bx;
                mcy[k] = by;
                for (int p = 0; p < int'(TN); p++) cov[k][p] = in_circ(px[p], py[p], bx, by);
            end
            if (!changed) break;
        end
        m_union = 0;
        for (int p = 0; p < int'(TN); p++) begin
            oth = 1'b0;
            for (int j = 0; j < int'(TNC); j++) oth |= cov[j][p];
            if (oth) m_union++;
        end
    endtask

    task automatic load_points(input bit bub);
        for (int p = 0; p < int'(TN); p++) begin
            if (bub) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    x = TCW'($urandom);
                    y = TCW'($urandom);
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            x = TCW'(px[p]);
            y = TCW'(py[p]);
            @(posedge clk); #1;
            if (p == 0) begin
                check("start_clr_cx", 32'(c_x), 0);
                check("start_busy", 32'(busy), 1);
            end
        end
        in_valid = 1'b0;
    endtask

    // Waits for done with junk on the input bus, then checks results and the FIN cycle.
    task automatic finish_job(input string tag, input logic [CXW-1:0] ecx, input logic [CXW-1:0] ecy,
                              input int elat, input int ecov);
        int cyc;
        bit got;
        cyc = 0;
        got = 1'b0;
        check({tag, "_busy_run"}, 32'(busy), 1);
        while (!got && cyc < elat + 64) begin
            in_valid = 1'($urandom_range(0, 1));
            x = TCW'($urandom);
            y = TCW'($urandom);
            @(posedge clk); #1;
            cyc++;
            if (done) got = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(got), 1);
        check({tag, "_latency"}, 32'(cyc), 32'(elat));
        check({tag, "_cx"}, 32'(c_x), 32'(ecx));
        check({tag, "_cy"}, 32'(c_y), 32'(ecy));
        check({tag, "_cover"}, 32'(cover_cnt), 32'(ecov));
        check({tag, "_busy_at_done"}, 32'(busy), 0);
        in_valid = 1'b1;
        x = 4'd3;
        y = 4'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_done_pulse"}, 32'(done), 0);
        check({tag, "_fin_ignore"}, 32'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_hold_cx"}, 32'(c_x), 32'(ecx));
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        x        = '0;
        y        = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cx", 32'(c_x), 0);
        check("rst_cy", 32'(c_y), 0);
        check("rst_cover", 32'(cover_cnt), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int p = 0; p < int'(TN); p++) begin px[p] = 5; py[p] = 5; end
        load_points(1'b0);
        finish_job("single", pack2(5, 0), pack2(1, 0), lat(2), COUNT_ON ? 5 : 0);

        for (int p = 0; p < int'(TN); p++) begin
            px[p] = (p < 3) ? 2 : 12;
            py[p] = (p < 3) ? 2 : 12;
        end
        load_points(1'b0);
        finish_job("cluster", pack2(0, 12), pack2(0, 8), lat(2), COUNT_ON ? 5 : 0);

        load_points(1'b1);
        finish_job("cluster_bub", pack2(0, 12), pack2(0, 8), lat(2), COUNT_ON ? 5 : 0);

        for (int p = 0; p < int'(TN); p++) begin px[p] = 15; py[p] = 15; end
        load_points(1'b0);
        finish_job("edge", pack2(15, 0), pack2(11, 0), lat(2), COUNT_ON ? 5 : 0);

        // Abort during the second circle's scan, after circle 0 was written.
        for (int p = 0; p < int'(TN); p++) begin px[p] = 5; py[p] = 5; end
        load_points(1'b0);
        repeat (PER_CIRC + 100) @(posedge clk);
        #1;
        check("mid_cx", 32'(c_x), 32'(pack2(5, 0)));
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_cx", 32'(c_x), 0);
        check("abort_cy", 32'(c_y), 0);
        check("abort_cover", 32'(cover_cnt), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_no_done", 32'(done), 0);
        end
        rst_n = 1'b1;
        for (int p = 0; p < int'(TN); p++) begin
            px[p] = (p < 3) ? 2 : 12;
            py[p] = (p < 3) ? 2 : 12;
        end
        load_points(1'b1);
        finish_job("after_abort", pack2(0, 12), pack2(0, 8), lat(2), COUNT_ON ? 5 : 0);

        for (int j = 0; j < 2; j++) begin
            for (int p = 0; p < int'(TN); p++) begin
                px[p] = int'($urandom_range(0, GRID - 1));
                py[p] = int'($urandom_range(0, GRID - 1));
            end
            run_model();
            load_points(1'b1);
            finish_job("rand", pack2(mcx[0], mcx[1]), pack2(mcy[0], mcy[1]),
                       lat(m_rounds), COUNT_ON ? m_union : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
